// File: rtl/ddr_arb_pkg.sv
// Shared encodings for the DDR read-channel arbiter: mux select codes, requester indices, FSM states.
package ddr_arb_pkg;

    localparam logic [1:0] SW_IDLE    = 2'd0;
    localparam logic [1:0] SW_WEIGHTS = 2'd1;
    localparam logic [1:0] SW_BIAS    = 2'd2;
    localparam logic [1:0] SW_DATA    = 2'd3;

    localparam logic [1:0] REQ_WEIGHTS = 2'd0;
    localparam logic [1:0] REQ_BIAS    = 2'd1;
    localparam logic [1:0] REQ_DATA    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CONF,
        ST_XFER,
        ST_RELEASE
    } arb_state_e;

    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return REQ_BIAS;
            3'b100:  return REQ_DATA;
            default: return REQ_WEIGHTS;
        endcase
    endfunction

    function automatic logic [1:0] idx_to_sw(input logic [1:0] idx);
        case (idx)
            REQ_WEIGHTS: return SW_WEIGHTS;
            REQ_BIAS:    return SW_BIAS;
            REQ_DATA:    return SW_DATA;
            default:     return SW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first set request at or above ptr_i, searching upward mod 3.
module rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] pick_o,
    output logic       valid_o
);

    logic [2:0] rot;
    logic [2:0] rpick;

    // Rotate so bit 0 is the pointer position, fixed-priority pick, rotate back.
    always_comb begin
        case (ptr_i)
            2'd1:    rot = {req_i[0], req_i[2:1]};
            2'd2:    rot = {req_i[1:0], req_i[2]};
            default: rot = req_i;
        endcase

        if (rot[0])      rpick = 3'b001;
        else if (rot[1]) rpick = 3'b010;
        else if (rot[2]) rpick = 3'b100;
        else             rpick = 3'b000;

        case (ptr_i)
            2'd1:    pick_o = {rpick[1:0], rpick[2]};
            2'd2:    pick_o = {rpick[0], rpick[2:1]};
            default: pick_o = rpick;
        endcase

        valid_o = |req_i;
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin owner of the shared DDR read channel; snoops conf/len/pops to release after each burst.
// Optional stall watchdog enabled by defining DDR_ARB_WATCHDOG_EN.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int SINGLE_LEN  = 20,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [1:0]            switch,
    input  logic                  ddr_conf,
    input  logic [SINGLE_LEN-1:0] ddr_len,
    input  logic                  ddr_fifo_req,
    input  logic                  ddr_fifo_empty,
    output logic                  err
);

    arb_state_e            state_q, state_d;
    logic [2:0]            gnt_q, gnt_d;
    logic [2:0]            done_q, done_d;
    logic [1:0]            sw_q, sw_d;
    logic [1:0]            sel_q, sel_d;
    logic [1:0]            rr_q, rr_d;
    logic [SINGLE_LEN-1:0] cnt_q, cnt_d;
    logic [SINGLE_LEN-1:0] len_q, len_d;
    logic                  err_q, err_d;
    logic [2:0]            pick;
    logic                  pick_vld;
    logic                  pop;

`ifdef DDR_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = |WDOG_CYCLES;
`endif

    assign pop = ddr_fifo_req & ~ddr_fifo_empty;

    rr_pick3 u_pick (
        .req_i   (req),
        .ptr_i   (rr_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sw_d    = sw_q;
        done_d  = '0;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
`ifdef DDR_ARB_WATCHDOG_EN
        wdog_d  = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    sel_d   = oh_to_idx(pick);
                    sw_d    = idx_to_sw(oh_to_idx(pick));
                    state_d = ST_WAIT_CONF;
                end
            end
            ST_WAIT_CONF: begin
                if (ddr_conf) begin
                    len_d = ddr_len;
                    cnt_d = '0;
                    if (ddr_len == '0) begin
                        state_d = ST_RELEASE;
                        gnt_d   = '0;
                        sw_d    = SW_IDLE;
                        done_d  = gnt_q;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (~|(req & gnt_q)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    sw_d    = SW_IDLE;
                end
            end
            ST_XFER: begin
                // switch is registered, so the final pop still sees the mux routed this cycle.
                if (pop) begin
                    cnt_d = cnt_q + SINGLE_LEN'(1);
                    if (cnt_q == len_q - SINGLE_LEN'(1)) begin
                        state_d = ST_RELEASE;
                        gnt_d   = '0;
                        sw_d    = SW_IDLE;
                        done_d  = gnt_q;
                    end
                end
            end
            ST_RELEASE: begin
                rr_d    = (sel_q == REQ_DATA) ? REQ_WEIGHTS : sel_q + 2'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DDR_ARB_WATCHDOG_EN
        if ((state_q == ST_WAIT_CONF || state_q == ST_XFER) && state_d == state_q && !pop) begin
            if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = ST_RELEASE;
                gnt_d   = '0;
                sw_d    = SW_IDLE;
                done_d  = '0;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            sw_q    <= SW_IDLE;
            sel_q   <= REQ_WEIGHTS;
            rr_q    <= REQ_WEIGHTS;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sw_q    <= sw_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

`ifdef DDR_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign switch = sw_q;

endmodule
